// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch PC sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    ERR  = 3'd4
  } fetch_state_e;

  localparam int         INSTR_BYTES = 4;
  localparam logic [1:0] ALIGN_MASK  = 2'(INSTR_BYTES - 1);

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Single-entry valid/ready holding register between fetch and decode.
module fetch_out_reg #(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             flush,
  input  logic             ready,
  input  logic [Width-1:0] load_instr,
  input  logic [Width-1:0] load_pc,
  output logic             valid,
  output logic [Width-1:0] instr,
  output logic [Width-1:0] pc
);

  // Flush wins over a same-cycle consume or load: a redirect discards the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= '0;
      pc    <= '0;
    end else if (load && !flush) begin
      instr <= load_instr;
      pc    <= load_pc;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Architectural PC plus one-outstanding instruction-fetch sequencer with redirect/kill handling.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int               Width       = 32,
  parameter logic [Width-1:0] ResetVector = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [Width-1:0] PC,
  input  logic [Width-1:0] PCPlus4,
  input  logic             RedirectValid,
  input  logic [Width-1:0] RedirectPC,
  output logic             IReqValid,
  input  logic             IReqReady,
  output logic [Width-1:0] IReqAddr,
  input  logic             IRspValid,
  input  logic [Width-1:0] IRspData,
  output logic             InstrValid,
  input  logic             InstrReady,
  output logic [Width-1:0] Instr,
  output logic [Width-1:0] InstrPC,
  output logic             MisalignErr
);

  fetch_state_e     state;
  logic [Width-1:0] pc;
  logic             kill;
  logic             req_valid;
  logic             misalign;

  logic redir_aligned;
  logic accept;
  logic rsp_take;
  logic consume;
  logic old_req_outstanding;

  assign redir_aligned = is_aligned(RedirectPC[1:0]);
  assign accept        = req_valid && IReqReady;
  assign consume       = InstrValid && InstrReady;
  assign rsp_take      = (state == WAIT) && IRspValid && !kill && !RedirectValid;

  // A request already handed to memory whose response has not yet come back.
  assign old_req_outstanding = accept || ((state == WAIT) && !IRspValid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= ResetVector;
      kill      <= 1'b0;
      req_valid <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      // Only one response can be in flight, so any response retires a pending kill.
      if (IRspValid) begin
        kill <= 1'b0;
      end
      if (RedirectValid && old_req_outstanding) begin
        kill <= 1'b1;
      end

      if (RedirectValid) begin
        pc       <= RedirectPC;
        misalign <= !redir_aligned;
        if (!redir_aligned) begin
          state     <= ERR;
          req_valid <= 1'b0;
        end else if (old_req_outstanding) begin
          state     <= WAIT;
          req_valid <= 1'b0;
        end else begin
          state     <= REQ;
          req_valid <= 1'b1;
        end
      end else begin
        unique case (state)
          IDLE: begin
            state     <= REQ;
            req_valid <= 1'b1;
          end
          REQ: begin
            if (IReqReady) begin
              state     <= WAIT;
              req_valid <= 1'b0;
            end
          end
          WAIT: begin
            if (IRspValid) begin
              if (kill) begin
                state     <= REQ;
                req_valid <= 1'b1;
              end else begin
                pc    <= PCPlus4;
                state <= HOLD;
              end
            end
          end
          HOLD: begin
            if (consume) begin
              state     <= REQ;
              req_valid <= 1'b1;
            end
          end
          ERR: begin
            state <= ERR;
          end
          default: begin
            state     <= IDLE;
            req_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  fetch_out_reg #(
    .Width(Width)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (rsp_take),
    .flush     (RedirectValid),
    .ready     (InstrReady),
    .load_instr(IRspData),
    .load_pc   (pc),
    .valid     (InstrValid),
    .instr     (Instr),
    .pc        (InstrPC)
  );

  assign PC          = pc;
  assign IReqAddr    = pc;
  assign IReqValid   = req_valid;
  assign MisalignErr = misalign;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized bench for fetch_pc_unit with a memory model and an expected-PC-stream reference.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PC, PCPlus4, RedirectPC, IReqAddr, IRspData, Instr, InstrPC;
  logic        RedirectValid, IReqValid, IReqReady, IRspValid;
  logic        InstrValid, InstrReady, MisalignErr;

  always #5 clk = ~clk;

  // External PC+4 adder that sits beside the fetch unit.
  assign PCPlus4 = PC + 32'd4;

  fetch_pc_unit #(.Width(32), .ResetVector(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .PC(PC), .PCPlus4(PCPlus4),
    .RedirectValid(RedirectValid), .RedirectPC(RedirectPC),
    .IReqValid(IReqValid), .IReqReady(IReqReady), .IReqAddr(IReqAddr),
    .IRspValid(IRspValid), .IRspData(IRspData),
    .InstrValid(InstrValid), .InstrReady(InstrReady),
    .Instr(Instr), .InstrPC(InstrPC), .MisalignErr(MisalignErr)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cycle = 0;

  // Memory model: one outstanding request, in-order, latency lat_min..lat_max edges.
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int unsigned lat_min, lat_max, ready_pct;

  // Stimulus knobs and reference state.
  logic        redir_req;
  logic [31:0] redir_target;
  logic [31:0] exp_pc;
  logic        err_mode;
  logic        accepted, delivered;
  int          deliv_cnt;
  logic [31:0] dpc [8];
  int          dcyc [8];
  int          dptr;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Called at a falling edge: drive inputs for the coming rising edge, score what
  // that edge will do, then advance to the next falling edge.
  task automatic step();
    accepted  = 1'b0;
    delivered = 1'b0;
    IRspValid = 1'b0;
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        IRspValid = 1'b1;
        IRspData  = word_at(mem_addr);
        mem_busy  = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    IReqReady     = !mem_busy && ($urandom_range(99) < ready_pct);
    RedirectValid = redir_req;
    RedirectPC    = redir_target;

    if (IReqValid && IReqReady) begin
      accepted = 1'b1;
      mem_busy = 1'b1;
      mem_addr = IReqAddr;
      mem_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
      n_cmp++;
      if (err_mode || IReqAddr !== exp_pc) begin
        n_bad++;
        $display("FAIL req_addr: got %h (err_mode=%0b) expected %h", IReqAddr, err_mode, exp_pc);
      end
    end
    n_cmp++;
    if (IReqValid && InstrValid) begin
      n_bad++;
      $display("FAIL req_while_holding: IReqValid=%0b InstrValid=%0b expected not both", IReqValid, InstrValid);
    end
    if (InstrValid && InstrReady && !RedirectValid) begin
      delivered = 1'b1;
      n_cmp++;
      if (InstrPC !== exp_pc || Instr !== word_at(exp_pc)) begin
        n_bad++;
        $display("FAIL deliver: got pc=%h instr=%h expected pc=%h instr=%h", InstrPC, Instr, exp_pc, word_at(exp_pc));
      end
      if (dptr < 8) begin
        dpc[dptr]  = InstrPC;
        dcyc[dptr] = cycle;
        dptr++;
      end
      exp_pc = exp_pc + 32'd4;
      deliv_cnt++;
    end
    if (RedirectValid) begin
      exp_pc   = RedirectPC;
      err_mode = (RedirectPC[1:0] != 2'b00);
    end
    @(posedge clk);
    cycle++;
    @(negedge clk);
    redir_req     = 1'b0;
    RedirectValid = 1'b0;
  endtask

  task automatic run_until(input int n, input int budget);
    int g = 0;
    while (dptr < n && g < budget) begin
      step();
      g++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0;
    IReqReady = 1'b0; IRspValid = 1'b0; IRspData = '0;
    RedirectValid = 1'b0; RedirectPC = '0; redir_req = 1'b0; redir_target = '0;
    InstrReady = 1'b0; exp_pc = '0; err_mode = 1'b0; dptr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ready_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    n_cmp++;
    if (IReqValid !== 1'b0 || PC !== 32'h0 || IReqAddr !== 32'h0 || InstrValid !== 1'b0 ||
        Instr !== 32'h0 || InstrPC !== 32'h0 || MisalignErr !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values: got pc=%h req=%0b addr=%h iv=%0b instr=%h ipc=%h err=%0b expected all zero",
               PC, IReqValid, IReqAddr, InstrValid, Instr, InstrPC, MisalignErr);
    end
    step();
    n_cmp++;
    if (IReqValid !== 1'b1 || IReqAddr !== 32'h0) begin
      n_bad++;
      $display("FAIL first_req: got valid=%0b addr=%h expected 1 / 00000000", IReqValid, IReqAddr);
    end
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (PC !== 32'h0 || IReqValid !== 1'b0 || InstrValid !== 1'b0 || Instr !== 32'h0 || InstrPC !== 32'h0) begin
      n_bad++;
      $display("FAIL async_reset: got pc=%h req=%0b iv=%0b instr=%h ipc=%h expected zeros",
               PC, IReqValid, InstrValid, Instr, InstrPC);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    ready_pct = 100; lat_min = 1; lat_max = 1; InstrReady = 1'b1;
    run_until(3, 30);
    n_cmp++;
    if (dptr < 3 || dpc[0] !== 32'h0 || dpc[1] !== 32'h4 || dpc[2] !== 32'h8) begin
      n_bad++;
      $display("FAIL seq_pcs: got count=%0d pcs=%h %h %h expected 0 4 8", dptr, dpc[0], dpc[1], dpc[2]);
    end
    n_cmp++;
    if (dcyc[1] - dcyc[0] != 3 || dcyc[2] - dcyc[1] != 3) begin
      n_bad++;
      $display("FAIL seq_rate: got gaps %0d %0d expected 3 3", dcyc[1] - dcyc[0], dcyc[2] - dcyc[1]);
    end
  endtask

  task automatic test_stall();
    logic [31:0] i0, p0, pc0;
    int g = 0;
    InstrReady = 1'b0;
    while (!InstrValid && g < 20) begin step(); g++; end
    i0 = Instr; p0 = InstrPC; pc0 = PC;
    n_cmp++;
    if (pc0 !== p0 + 32'd4) begin
      n_bad++;
      $display("FAIL stall_pc_adv: got %h expected %h", pc0, p0 + 32'd4);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++;
      if (InstrValid !== 1'b1 || Instr !== i0 || InstrPC !== p0 || IReqValid !== 1'b0 || PC !== pc0) begin
        n_bad++;
        $display("FAIL stall_hold: got iv=%0b instr=%h ipc=%h req=%0b pc=%h expected 1 %h %h 0 %h",
                 InstrValid, Instr, InstrPC, IReqValid, PC, i0, p0, pc0);
      end
    end
    InstrReady = 1'b1;
    step();
    n_cmp++;
    if (!delivered) begin
      n_bad++;
      $display("FAIL stall_release: got delivered=%0b expected 1", delivered);
    end
  endtask

  task automatic test_redirect_wait();
    int g = 0;
    lat_min = 3; lat_max = 3; ready_pct = 100; InstrReady = 1'b1;
    accepted = 1'b0;
    while (!accepted && g < 20) begin step(); g++; end
    dptr = 0;
    redir_req = 1'b1; redir_target = 32'h100;
    step();
    run_until(1, 40);
    n_cmp++;
    if (dptr < 1 || dpc[0] !== 32'h100) begin
      n_bad++;
      $display("FAIL redir_wait: got count=%0d pc=%h expected 00000100", dptr, dpc[0]);
    end
  endtask

  task automatic test_redirect_accept();
    int g = 0;
    do_reset();
    ready_pct = 100; lat_min = 1; lat_max = 1; InstrReady = 1'b1;
    while (!(IReqValid && IReqAddr == 32'h8) && g < 30) begin step(); g++; end
    dptr = 0;
    redir_req = 1'b1; redir_target = 32'h200;
    step();
    n_cmp++;
    if (!accepted) begin
      n_bad++;
      $display("FAIL redir_accept_hs: got accepted=%0b expected 1", accepted);
    end
    run_until(1, 30);
    n_cmp++;
    if (dptr < 1 || dpc[0] !== 32'h200) begin
      n_bad++;
      $display("FAIL redir_accept: got count=%0d pc=%h expected 00000200", dptr, dpc[0]);
    end
  endtask

  task automatic test_misalign();
    int g = 0;
    InstrReady = 1'b0;
    while (!InstrValid && g < 30) begin step(); g++; end
    InstrReady = 1'b1;
    redir_req = 1'b1; redir_target = 32'h102;
    step();
    n_cmp++;
    if (MisalignErr !== 1'b1 || PC !== 32'h102 || InstrValid !== 1'b0 || IReqValid !== 1'b0) begin
      n_bad++;
      $display("FAIL misalign_enter: got err=%0b pc=%h iv=%0b req=%0b expected 1 00000102 0 0",
               MisalignErr, PC, InstrValid, IReqValid);
    end
    for (int k = 0; k < 6; k++) begin
      step();
      n_cmp++;
      if (IReqValid !== 1'b0 || MisalignErr !== 1'b1) begin
        n_bad++;
        $display("FAIL misalign_hold: got req=%0b err=%0b expected 0 1", IReqValid, MisalignErr);
      end
    end
    dptr = 0;
    redir_req = 1'b1; redir_target = 32'h300;
    step();
    n_cmp++;
    if (MisalignErr !== 1'b0 || IReqValid !== 1'b1 || IReqAddr !== 32'h300) begin
      n_bad++;
      $display("FAIL misalign_exit: got err=%0b req=%0b addr=%h expected 0 1 00000300", MisalignErr, IReqValid, IReqAddr);
    end
    run_until(1, 30);
    n_cmp++;
    if (dptr < 1 || dpc[0] !== 32'h300) begin
      n_bad++;
      $display("FAIL misalign_resume: got count=%0d pc=%h expected 00000300", dptr, dpc[0]);
    end
  endtask

  task automatic test_wrap();
    int g = 0;
    ready_pct = 100; lat_min = 1; lat_max = 2; InstrReady = 1'b1;
    while (mem_busy && g < 10) begin step(); g++; end
    dptr = 0;
    redir_req = 1'b1; redir_target = 32'hFFFF_FFFC;
    step();
    run_until(2, 40);
    n_cmp++;
    if (dptr < 2 || dpc[0] !== 32'hFFFF_FFFC || dpc[1] !== 32'h0) begin
      n_bad++;
      $display("FAIL wrap: got count=%0d pcs=%h %h expected fffffffc 00000000", dptr, dpc[0], dpc[1]);
    end
  endtask

  task automatic test_random();
    int start = deliv_cnt;
    ready_pct = 60; lat_min = 1; lat_max = 4;
    for (int k = 0; k < 1200; k++) begin
      int unsigned r;
      InstrReady = ($urandom_range(99) < 70);
      r = $urandom_range(99);
      if (r < 4) begin
        redir_req = 1'b1;
        redir_target = (r == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & 32'h0000_0FFC);
      end else if (r == 4) begin
        redir_req = 1'b1;
        redir_target = ($urandom & 32'h0000_0FFC) | 32'h2;
      end
      step();
    end
    n_cmp++;
    if (deliv_cnt - start < 20) begin
      n_bad++;
      $display("FAIL random_progress: got %0d deliveries expected at least 20", deliv_cnt - start);
    end
  endtask

  initial begin
    deliv_cnt = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_accept();
    test_misalign();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
